reg_file_cfg: RTL and testbench

// Parametrised configuration register file for the system controller. Successor to the

---
 rtl/reg_file_cfg.sv | 137 +++++++++++++
 tb/tb_reg_file_cfg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_cfg.sv
// Parametrised configuration register file: per-address reset values, read-only protection,
// 1- or 2-cycle read latency, selectable write/read collision policy, error and change reporting.
module reg_file_cfg #(
  parameter int                     DEPTH     = 16,
  parameter int                     WIDTH     = 8,
  parameter int                     ADDR_W    = 4,
  parameter int                     NUM_EXP   = 4,
  parameter int                     RD_LAT    = 1,
  parameter int                     COLL_MODE = 0,
  parameter logic [DEPTH-1:0]       RO_MASK   = '0,
  parameter logic [DEPTH*WIDTH-1:0] RST_VAL   = ((DEPTH*WIDTH)'(8'h20) << (3*WIDTH)) |
                                                ((DEPTH*WIDTH)'(8'h81) << (2*WIDTH))
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDR_W-1:0]        Address,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [WIDTH-1:0]         WrData,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdValid,
  output logic                     Err,
  output logic [NUM_EXP-1:0]       RegChg,
  output logic [NUM_EXP*WIDTH-1:0] REG_OUT
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [WIDTH-1:0]   regs_d [DEPTH];
  logic [NUM_EXP-1:0] chg_q, chg_d;

  logic               addr_ok_s, ro_s, coll_s, rej_s;
  logic               wr_ok_s, wr_bad_s, rd_acc_s, rd_err_s, nord_err_s;
  logic [WIDTH-1:0]   rd_old_s, rd_val_s;

  logic               p1_valid_q, p1_rerr_q, p1_werr_q;
  logic [WIDTH-1:0]   p1_data_q;

  // Request decode: full-width address match, legality, collision policy and read value.
  always_comb begin
    addr_ok_s = ({1'b0, Address} < DEPTH_L);
    rd_old_s  = '0;
    ro_s      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_old_s = rd_old_s | ((Address == ADDR_W'(i)) ? regs_q[i] : '0);
      ro_s     = ro_s | ((Address == ADDR_W'(i)) & RO_MASK[i]);
    end
    coll_s     = WrEn & RdEn;
    rej_s      = coll_s & (COLL_MODE == 32'sd0);
    wr_ok_s    = WrEn & ~rej_s & addr_ok_s & ~ro_s;
    wr_bad_s   = WrEn & ~rej_s & ~wr_ok_s;
    rd_acc_s   = RdEn & ~rej_s;
    // Errors of a request carrying a read travel with the read; others report next cycle.
    rd_err_s   = rd_acc_s & (~addr_ok_s | wr_bad_s);
    nord_err_s = ~rd_acc_s & (wr_bad_s | rej_s);
    if (!addr_ok_s) begin
      rd_val_s = '0;
    end else if (coll_s && (COLL_MODE == 32'sd1) && wr_ok_s) begin
      rd_val_s = WrData;
    end else begin
      rd_val_s = rd_old_s;
    end
  end

  // Register next state and per-export change detection.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (wr_ok_s && (Address == ADDR_W'(i))) ? WrData : regs_q[i];
    end
    chg_d = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      chg_d[i] = wr_ok_s && (Address == ADDR_W'(i)) && (WrData != regs_q[i]);
    end
  end

  // Storage, change pulses and first read stage; RdData holds while no read is accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RST_VAL[i*WIDTH +: WIDTH];
      end
      chg_q      <= '0;
      p1_valid_q <= 1'b0;
      p1_data_q  <= '0;
      p1_rerr_q  <= 1'b0;
      p1_werr_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      chg_q      <= chg_d;
      p1_valid_q <= rd_acc_s;
      p1_data_q  <= rd_acc_s ? rd_val_s : p1_data_q;
      p1_rerr_q  <= rd_err_s;
      p1_werr_q  <= nord_err_s;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             p2_valid_q, p2_err_q;
      logic [WIDTH-1:0] p2_data_q;

      // Second read stage; write-only errors bypass it to keep their one-cycle timing.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          p2_valid_q <= 1'b0;
          p2_data_q  <= '0;
          p2_err_q   <= 1'b0;
        end else begin
          p2_valid_q <= p1_valid_q;
          p2_data_q  <= p1_valid_q ? p1_data_q : p2_data_q;
          p2_err_q   <= p1_rerr_q;
        end
      end

      assign RdValid = p2_valid_q;
      assign RdData  = p2_data_q;
      assign Err     = p2_err_q | p1_werr_q;
    end else begin : g_lat1
      assign RdValid = p1_valid_q;
      assign RdData  = p1_data_q;
      assign Err     = p1_rerr_q | p1_werr_q;
    end
  endgenerate

  assign RegChg = chg_q;

  generate
    for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
      assign REG_OUT[g*WIDTH +: WIDTH] = regs_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_cfg.sv
// Self-checking bench: three configurations of reg_file_cfg driven in parallel and compared
// every cycle against a cycle-scheduled behavioural model.
module tb_reg_file_cfg;

  localparam int NI   = 3;
  localparam int MAXC = 2048;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] addr;
  logic       we, re;
  logic [7:0] wd;

  logic [7:0]  rd_data  [NI];
  logic        rd_valid [NI];
  logic        err      [NI];
  logic [3:0]  chg      [NI];
  logic [31:0] reg_out  [NI];

  always #5 CLK = ~CLK;

  // u0: defaults (16 regs, latency 1, reject collisions)
  reg_file_cfg u0 (
    .CLK(CLK), .RST(RST), .Address(addr), .WrEn(we), .RdEn(re), .WrData(wd),
    .RdData(rd_data[0]), .RdValid(rd_valid[0]), .Err(err[0]), .RegChg(chg[0]), .REG_OUT(reg_out[0])
  );

  // u1: 12 regs, reg3 read-only, write-first collisions
  reg_file_cfg #(.DEPTH(12), .RO_MASK(12'h008), .COLL_MODE(1), .RD_LAT(1)) u1 (
    .CLK(CLK), .RST(RST), .Address(addr), .WrEn(we), .RdEn(re), .WrData(wd),
    .RdData(rd_data[1]), .RdValid(rd_valid[1]), .Err(err[1]), .RegChg(chg[1]), .REG_OUT(reg_out[1])
  );

  // u2: 16 regs, latency 2, read-first collisions, reg5 read-only
  reg_file_cfg #(.DEPTH(16), .RO_MASK(16'h0020), .COLL_MODE(2), .RD_LAT(2)) u2 (
    .CLK(CLK), .RST(RST), .Address(addr), .WrEn(we), .RdEn(re), .WrData(wd),
    .RdData(rd_data[2]), .RdValid(rd_valid[2]), .Err(err[2]), .RegChg(chg[2]), .REG_OUT(reg_out[2])
  );

  int          cfg_depth [NI] = '{16, 12, 16};
  int          cfg_lat   [NI] = '{1, 1, 2};
  int          cfg_mode  [NI] = '{0, 1, 2};
  logic [15:0] cfg_ro    [NI] = '{16'h0000, 16'h0008, 16'h0020};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] m_regs [NI][16];
  logic [7:0] hold   [NI];
  bit         s_v    [NI][MAXC];
  logic [7:0] s_d    [NI][MAXC];
  bit         s_e    [NI][MAXC];
  logic [3:0] s_c    [NI][MAXC];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s u%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) m_regs[k][i] = 8'h00;
      m_regs[k][2] = 8'h81;
      m_regs[k][3] = 8'h20;
      hold[k] = 8'h00;
      for (int c = cyc + 1; c < MAXC; c++) begin
        s_v[k][c] = 1'b0;
        s_e[k][c] = 1'b0;
        s_c[k][c] = 4'h0;
      end
    end
  endtask

  // Apply the current inputs to model k for the edge that completes cycle n.
  task automatic model_apply(input int k, input int n);
    int  slot;
    bit  legal, ro, coll, rej, wr_ok, wr_bad, rd_acc;
    logic [7:0] rv;
    slot   = n + cfg_lat[k] - 1;
    legal  = (int'(addr) < cfg_depth[k]);
    ro     = legal && cfg_ro[k][addr];
    coll   = we && re;
    rej    = coll && (cfg_mode[k] == 0);
    wr_ok  = we && !rej && legal && !ro;
    wr_bad = we && !rej && !wr_ok;
    rd_acc = re && !rej;
    if (rd_acc) begin
      if (!legal)                               rv = 8'h00;
      else if (coll && cfg_mode[k] == 1 && wr_ok) rv = wd;
      else                                      rv = m_regs[k][addr];
      s_v[k][slot] = 1'b1;
      s_d[k][slot] = rv;
      s_e[k][slot] = s_e[k][slot] | !legal | wr_bad;
    end else begin
      s_e[k][n] = s_e[k][n] | wr_bad | rej;
    end
    if (wr_ok) begin
      if (addr < 4 && wd != m_regs[k][addr]) s_c[k][n][addr[1:0]] = 1'b1;
      m_regs[k][addr] = wd;
    end
  endtask

  task automatic check_all();
    logic [7:0] ed;
    for (int k = 0; k < NI; k++) begin
      ed = s_v[k][cyc] ? s_d[k][cyc] : hold[k];
      hold[k] = ed;
      chk("rdvalid", k, 32'(rd_valid[k]), 32'(s_v[k][cyc]));
      chk("rddata",  k, 32'(rd_data[k]),  32'(ed));
      chk("err",     k, 32'(err[k]),      32'(s_e[k][cyc]));
      chk("regchg",  k, 32'(chg[k]),      32'(s_c[k][cyc]));
      chk("regout",  k, reg_out[k], {m_regs[k][3], m_regs[k][2], m_regs[k][1], m_regs[k][0]});
    end
  endtask

  task automatic step(input logic [3:0] a, input logic w, input logic r, input logic [7:0] d);
    addr = a; we = w; re = r; wd = d;
    for (int k = 0; k < NI; k++) model_apply(k, cyc + 1);
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    we = 1'b0; re = 1'b0;
    RST = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_valid",  k, 32'(rd_valid[k]), 32'd0);
      chk("rst_err",    k, 32'(err[k]),      32'd0);
      chk("rst_data",   k, 32'(rd_data[k]),  32'd0);
      chk("rst_regout", k, reg_out[k],       32'h2081_0000);
    end
    repeat (2) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      check_all();
    end
    RST = 1'b1;
  endtask

  initial begin
    addr = 4'h0; we = 1'b0; re = 1'b0; wd = 8'h00;
    @(negedge CLK);
    do_reset();

    // Reset image visible after release
    step(4'h0, 1'b0, 1'b0, 8'h00);
    chk("t1_reg2", 0, 32'(reg_out[0][23:16]), 32'h81);
    chk("t1_reg3", 0, 32'(reg_out[0][31:24]), 32'h20);

    // Write then back-to-back read of reg1
    step(4'h1, 1'b1, 1'b0, 8'h5A);
    chk("t2_chg", 0, 32'(chg[0]), 32'h2);
    step(4'h1, 1'b0, 1'b1, 8'h00);
    chk("t2_rd",  0, 32'(rd_data[0]), 32'h5A);
    chk("t2_chg_once", 0, 32'(chg[0]), 32'h0);

    // Read-only reg3 on u1
    step(4'h3, 1'b1, 1'b0, 8'hFF);
    chk("t3_err", 1, 32'(err[1]), 32'h1);
    chk("t3_chg", 1, 32'(chg[1]), 32'h0);
    chk("t3_reg3", 1, 32'(reg_out[1][31:24]), 32'h20);
    step(4'h0, 1'b0, 1'b0, 8'h00);
    chk("t3_err_pulse", 1, 32'(err[1]), 32'h0);

    // Out-of-range address on the 12-deep u1
    step(4'hE, 1'b0, 1'b1, 8'h00);
    chk("t4_rd_valid", 1, 32'(rd_valid[1]), 32'h1);
    chk("t4_rd_err",   1, 32'(err[1]),      32'h1);
    chk("t4_rd_data",  1, 32'(rd_data[1]),  32'h0);
    step(4'hE, 1'b1, 1'b0, 8'h77);
    chk("t4_wr_err", 1, 32'(err[1]), 32'h1);

    // Collision at reg2 across all three policies
    do_reset();
    step(4'h2, 1'b1, 1'b1, 8'h11);
    chk("t5_m0_err",   0, 32'(err[0]),      32'h1);
    chk("t5_m0_valid", 0, 32'(rd_valid[0]), 32'h0);
    chk("t5_m0_reg2",  0, 32'(reg_out[0][23:16]), 32'h81);
    chk("t5_m1_data",  1, 32'(rd_data[1]),  32'h11);
    step(4'h0, 1'b0, 1'b0, 8'h00);
    chk("t5_m2_data",  2, 32'(rd_data[2]),  32'h81);
    chk("t5_m2_reg2",  2, 32'(reg_out[2][23:16]), 32'h11);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom));
    end

    // Pipelined reads on the latency-2 instance, then reset mid-stream
    step(4'h0, 1'b0, 1'b0, 8'h00);
    step(4'h0, 1'b0, 1'b1, 8'h00);
    chk("t6_lat_first", 2, 32'(rd_valid[2]), 32'h0);
    step(4'h1, 1'b0, 1'b1, 8'h00);
    chk("t6_v0", 2, 32'(rd_valid[2]), 32'h1);
    step(4'h2, 1'b0, 1'b1, 8'h00);
    chk("t6_v1", 2, 32'(rd_valid[2]), 32'h1);
    step(4'h0, 1'b0, 1'b0, 8'h00);
    chk("t6_v2", 2, 32'(rd_valid[2]), 32'h1);
    step(4'h0, 1'b0, 1'b0, 8'h00);
    chk("t6_end", 2, 32'(rd_valid[2]), 32'h0);
    step(4'h0, 1'b0, 1'b1, 8'h00);
    step(4'h1, 1'b0, 1'b1, 8'h00);
    do_reset();
    repeat (4) step(4'h0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
